// File: rtl/serial_bit_source_pkg.sv
// serial_bit_source_pkg: shared constants and state encoding for the serial bit source
package serial_bit_source_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

endpackage

// File: rtl/serial_bit_source_bit_shifter.sv
// bit_shifter: parameterised load/shift register with selectable output end
//   clk   - clock
//   clear - synchronous clear to all zeros
//   load  - load d (has priority over shift)
//   shift - move one bit toward the output end, zero-fill
//   d     - parallel load word
//   tap   - bit currently at the output end
module bit_shifter #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             tap
);

    logic [WIDTH-1:0] sh;

    always_ff @(posedge clk) begin
        if (clear)
            sh <= '0;
        else if (load)
            sh <= d;
        else if (shift)
            sh <= MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
    end

    assign tap = MSB_FIRST ? sh[WIDTH-1] : sh[0];

endmodule

// File: rtl/serial_bit_source.sv
// serial_bit_source: parallel-to-serial converter with a one-word holding buffer
//   clk        - clock, all state on rising edge
//   rst_n      - synchronous active-low reset
//   clr        - synchronous soft clear, same effect as reset
//   data_in    - parallel word, taken when valid_in && ready_out
//   valid_in   - data_in valid
//   ready_out  - a word can be accepted this cycle
//   a          - serial bit, IDLE_BIT when not sending
//   a_valid    - a carries a payload bit
//   words_sent - count of fully transmitted words, wraps
module serial_bit_source
    import serial_bit_source_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             a,
    output logic             a_valid,
    output logic [CNT_W-1:0] words_sent
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] hold;
    logic             hold_v;
    logic             clear, accept, last, tap;
    logic             load, from_hold, shift, hold_we, hold_clr, sent_inc;

    assign clear  = !rst_n || clr;
    assign accept = valid_in && !hold_v;
    assign last   = cnt == CW'(WIDTH - 1);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        load      = 1'b0;
        from_hold = 1'b0;
        shift     = 1'b0;
        hold_we   = 1'b0;
        hold_clr  = 1'b0;
        sent_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                if (!last) begin
                    shift   = 1'b1;
                    cnt_d   = cnt + CW'(1);
                    hold_we = accept;
                end else begin
                    // Last bit on the line: chain the next word with no gap if one is available.
                    sent_inc = 1'b1;
                    cnt_d    = '0;
                    if (hold_v) begin
                        load      = 1'b1;
                        from_hold = 1'b1;
                        hold_clr  = 1'b1;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt        <= '0;
            hold       <= '0;
            hold_v     <= 1'b0;
            words_sent <= '0;
        end else begin
            cnt        <= cnt_d;
            if (hold_we)
                hold <= data_in;
            hold_v     <= hold_we ? 1'b1 : hold_clr ? 1'b0 : hold_v;
            words_sent <= words_sent + CNT_W'(sent_inc);
        end
    end

    bit_shifter #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shifter (
        .clk  (clk),
        .clear(clear),
        .load (load),
        .shift(shift),
        .d    (from_hold ? hold : data_in),
        .tap  (tap)
    );

    assign ready_out = !hold_v;
    assign a_valid   = state == ST_SHIFT;
    assign a         = a_valid ? tap : IDLE_BIT;

endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source: table, directed and random checks against a queue-based model
module tb_serial_bit_source;

    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic [7:0]  data_in, data_in1;
    logic        valid_in, valid_in1;
    logic        ready_out, a, a_valid;
    logic [15:0] words_sent;
    logic        ready_out1, a1, a_valid1;
    logic [15:0] words_sent1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .a(a), .a_valid(a_valid), .words_sent(words_sent)
    );

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .data_in(data_in1), .valid_in(valid_in1),
        .ready_out(ready_out1), .a(a1), .a_valid(a_valid1), .words_sent(words_sent1)
    );

    // Model: queue of bits still to appear on the line, plus one held word.
    bit          mq[$];
    logic        m_hv;
    logic [7:0]  m_hold;
    logic [15:0] m_ws;

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) mq.push_back(w[i]);
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        logic acc;
        if (!rst_n || clr) begin
            mq.delete();
            m_hv = 1'b0;
            m_ws = '0;
        end else begin
            acc = v && !m_hv;
            if (mq.size() > 0) begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    m_ws = m_ws + 16'd1;
                    if (m_hv) begin
                        push_word(m_hold);
                        m_hv = 1'b0;
                    end else if (acc) begin
                        push_word(d);
                    end
                end else if (acc) begin
                    m_hold = d;
                    m_hv   = 1'b1;
                end
            end else if (acc) begin
                push_word(d);
            end
        end
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        model_step(v, d);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string n);
        chk({n, ".a_valid"}, 32'(a_valid), 32'(mq.size() > 0));
        chk({n, ".a"}, 32'(a), 32'(mq.size() > 0 ? mq[0] : 1'b1));
        chk({n, ".ready"}, 32'(ready_out), 32'(!m_hv));
        chk({n, ".words"}, 32'(words_sent), 32'(m_ws));
    endtask

    task automatic drain(input string n);
        for (int i = 0; i < 40 && mq.size() > 0; i++) begin
            tick(1'b0, 8'h00);
            check_model(n);
        end
        chk({n, ".drained"}, 32'(a_valid), 32'(0));
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       eav;
        logic       ea;
        logic       erdy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [15:0] s16;
        logic [7:0]  s8;
        logic [7:0]  bp_w[3];
        logic [15:0] ws0;
        int idx, ones, falls;
        logic prev;

        rst_n = 1'b0; clr = 1'b0; valid_in = 1'b0; data_in = '0;
        valid_in1 = 1'b0; data_in1 = '0;
        m_hv = 1'b0; m_hold = '0; m_ws = '0;

        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        chk("rst.a_valid", 32'(a_valid), 0);
        chk("rst.a", 32'(a), 1);
        chk("rst.ready", 32'(ready_out), 1);
        chk("rst.words", 32'(words_sent), 0);
        chk("rst.lsb_a", 32'(a1), 1);
        rst_n = 1'b1;
        tick(1'b0, 8'h00);
        check_model("idle");

        // Single word 8'hA5 MSB first: 1,0,1,0,0,1,0,1 then idle.
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d.a_valid", i), 32'(a_valid), 32'(tbl[i].eav));
            chk($sformatf("tbl%0d.a", i), 32'(a), 32'(tbl[i].ea));
            chk($sformatf("tbl%0d.ready", i), 32'(ready_out), 32'(tbl[i].erdy));
        end
        chk("single.words", 32'(words_sent), 1);

        // Back-to-back 8'h63, 8'h00.
        s16 = '0;
        for (int i = 1; i <= 16; i++) begin
            tick(i <= 2, i == 1 ? 8'h63 : 8'h00);
            check_model("b2b");
            s16 = {s16[14:0], a};
            chk($sformatf("b2b.av%0d", i), 32'(a_valid), 1);
            if (i >= 2 && i <= 8) chk($sformatf("b2b.rdy_low%0d", i), 32'(ready_out), 0);
            if (i == 9) chk("b2b.rdy_back", 32'(ready_out), 1);
        end
        chk("b2b.stream", 32'(s16), 32'h6300);
        tick(1'b0, 8'h00);
        chk("b2b.end_av", 32'(a_valid), 0);
        chk("b2b.words", 32'(words_sent), 3);

        // Second word arrives on the last-bit cycle: no gap.
        tick(1'b1, 8'hF0);
        for (int i = 0; i < 7; i++) tick(1'b0, 8'h00);
        tick(1'b1, 8'h0F);
        chk("gap0.av", 32'(a_valid), 1);
        chk("gap0.a", 32'(a), 0);
        check_model("gap0");
        drain("gap0");
        // One cycle later: exactly one idle cycle.
        tick(1'b1, 8'hAA);
        for (int i = 0; i < 7; i++) tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        chk("gap1.idle_av", 32'(a_valid), 0);
        chk("gap1.idle_a", 32'(a), 1);
        tick(1'b1, 8'h55);
        chk("gap1.av", 32'(a_valid), 1);
        chk("gap1.a", 32'(a), 0);
        check_model("gap1");
        drain("gap1");

        // LSB first, 8'h01.
        valid_in1 = 1'b1; data_in1 = 8'h01;
        tick(1'b0, 8'h00);
        valid_in1 = 1'b0;
        s8 = '0;
        for (int i = 0; i < 8; i++) begin
            s8[i] = a1;
            chk($sformatf("lsb.av%0d", i), 32'(a_valid1), 1);
            tick(1'b0, 8'h00);
        end
        chk("lsb.bits", 32'(s8), 32'h01);
        chk("lsb.end_av", 32'(a_valid1), 0);
        chk("lsb.words", 32'(words_sent1), 1);

        // Backpressure: valid held high through 3 distinct words.
        bp_w[0] = 8'h11; bp_w[1] = 8'h92; bp_w[2] = 8'h3C;
        ws0 = m_ws; idx = 0; ones = 0; falls = 0; prev = 1'b0;
        for (int c = 0; c < 100 && (idx < 3 || mq.size() > 0); c++) begin
            if (idx < 3) begin
                logic acc;
                acc = !m_hv;
                tick(1'b1, bp_w[idx]);
                if (acc) idx++;
            end else begin
                tick(1'b0, 8'h00);
            end
            check_model("bp");
            if (a_valid) ones++;
            if (prev && !a_valid) falls++;
            prev = a_valid;
        end
        tick(1'b0, 8'h00);
        if (prev && !a_valid) falls++;
        chk("bp.taken", 32'(idx), 3);
        chk("bp.words", 32'(words_sent - ws0), 3);
        chk("bp.bits", 32'(ones), 24);
        chk("bp.nogap", 32'(falls), 1);

        // Reset and clr mid-word with a word held.
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 8'hC3);
            tick(1'b1, 8'h3C);
            tick(1'b0, 8'h00);
            tick(1'b0, 8'h00);
            chk($sformatf("abort%0d.held", k), 32'(ready_out), 0);
            if (k == 0) rst_n = 1'b0; else clr = 1'b1;
            tick(1'b0, 8'h00);
            rst_n = 1'b1; clr = 1'b0;
            chk($sformatf("abort%0d.av", k), 32'(a_valid), 0);
            chk($sformatf("abort%0d.a", k), 32'(a), 1);
            chk($sformatf("abort%0d.ready", k), 32'(ready_out), 1);
            chk($sformatf("abort%0d.words", k), 32'(words_sent), 0);
            ones = 0;
            for (int i = 0; i < 20; i++) begin
                tick(1'b0, 8'h00);
                if (a_valid !== 1'b0 || a !== 1'b1) ones++;
            end
            chk($sformatf("abort%0d.residual", k), 32'(ones), 0);
        end

        // Random traffic with occasional soft clear.
        for (int c = 0; c < 3000; c++) begin
            logic v;
            logic [7:0] d;
            if (valid_in && m_hv) begin
                v = valid_in;
                d = data_in;
            end else begin
                v = $urandom_range(0, 99) < 20;
                d = 8'($urandom);
            end
            clr = $urandom_range(0, 299) == 0;
            tick(v, d);
            clr = 1'b0;
            check_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
